// File: rtl/frame_sched_pkg.sv
// Shared types and constants for the frame scheduler: FSM state encoding,
// the driver idle code and counter widths.
package frame_sched_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StSwap   = 3'd1,
        StArm    = 3'd2,
        StWaitGo = 3'd3,
        StScan   = 3'd4,
        StDone   = 3'd5
    } sched_state_e;

    // Driver state code meaning "halted / idle".
    localparam logic [2:0] DRV_HALT_DEFAULT = 3'd7;

    localparam int unsigned FRAME_CNT_W = 16;
    localparam int unsigned DROP_CNT_W  = 8;

    // Bits needed for a counter that holds 0 .. n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Free-running frame period counter. Emits a one-cycle tick at the last
// count of every period, independent of any enable.
module frame_tick_gen
    import frame_sched_pkg::*;
#(
    parameter int unsigned FRAME_PERIOD = 1000000
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);

    localparam int unsigned CNT_W = cnt_width(FRAME_PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_PERIOD - 1);

    logic [CNT_W-1:0] cnt_q;

    // Count 0 .. FRAME_PERIOD-1 and wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign tick_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/frame_scheduler.sv
// Frame scheduler: kicks the LCD driver once per frame tick, watches its
// state output for scan completion or timeout, and runs the double-buffer
// handshake with game logic (upd_req_o / upd_ack_i).
//
// Optional build macro FRAME_SCHED_STATS_EN: when defined, drop_cnt_o counts
// frames that were repeated because the back buffer was not ready
// (saturating, cleared by clr_i). When undefined drop_cnt_o is tied to 0.
module frame_scheduler
    import frame_sched_pkg::*;
#(
    parameter int unsigned FRAME_PERIOD    = 1000000,
    parameter int unsigned START_PULSE_LEN = 4,
    parameter int unsigned DRV_TIMEOUT     = 65536,
    parameter logic [2:0]  DRV_HALT        = DRV_HALT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable_i,
    input  logic                   clr_i,
    input  logic [2:0]             drv_state_i,
    output logic                   drv_start_o,
    output logic                   buf_sel_o,
    output logic                   upd_req_o,
    input  logic                   upd_ack_i,
    output logic                   busy_o,
    output logic [FRAME_CNT_W-1:0] frame_cnt_o,
    output logic                   overrun_o,
    output logic                   timeout_o,
    output logic [DROP_CNT_W-1:0]  drop_cnt_o
);

    // One phase counter serves both the start pulse length and the timeout.
    localparam int unsigned PH_MAX =
        (DRV_TIMEOUT > START_PULSE_LEN) ? DRV_TIMEOUT : START_PULSE_LEN;
    localparam int unsigned PH_W = cnt_width(PH_MAX);
    localparam logic [PH_W-1:0] PULSE_LAST   = PH_W'(START_PULSE_LEN - 1);
    localparam logic [PH_W-1:0] TIMEOUT_LAST = PH_W'(DRV_TIMEOUT - 1);

    sched_state_e state_q, state_d;

    logic                   tick;
    logic [PH_W-1:0]        phase_cnt_q;
    logic                   buf_sel_q;
    logic                   upd_req_q;
    logic                   back_ready_q;
    logic [FRAME_CNT_W-1:0] frame_cnt_q;
    logic                   overrun_q;
    logic                   timeout_q;

    logic drv_halted;
    logic phase_expired;
    logic swap_evt;
    logic done_evt;
    logic timeout_evt;
    logic overrun_evt;

    frame_tick_gen #(
        .FRAME_PERIOD (FRAME_PERIOD)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .tick_o (tick)
    );

    assign drv_halted = (drv_state_i == DRV_HALT);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: sequence one scan per accepted tick.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (tick && enable_i) begin
                    state_d = StSwap;
                end
            end
            StSwap: begin
                state_d = StArm;
            end
            StArm: begin
                if (phase_cnt_q == PULSE_LAST) begin
                    state_d = StWaitGo;
                end
            end
            StWaitGo: begin
                if (!drv_halted) begin
                    state_d = StScan;
                end else if (phase_expired) begin
                    state_d = StIdle;
                end
            end
            StScan: begin
                if (drv_halted) begin
                    state_d = StDone;
                end else if (phase_expired) begin
                    state_d = StIdle;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign phase_expired = (phase_cnt_q == TIMEOUT_LAST);

    // Outputs and one-cycle event strobes decoded from the current state.
    always_comb begin
        drv_start_o = 1'b0;
        busy_o      = 1'b1;
        swap_evt    = 1'b0;
        done_evt    = 1'b0;
        timeout_evt = 1'b0;
        unique case (state_q)
            StIdle:   busy_o      = 1'b0;
            StSwap:   swap_evt    = 1'b1;
            StArm:    drv_start_o = 1'b1;
            StWaitGo: timeout_evt = (state_d == StIdle);
            StScan:   timeout_evt = (state_d == StIdle);
            StDone:   done_evt    = 1'b1;
            default:  busy_o      = 1'b1;
        endcase
        overrun_evt = tick && (state_q != StIdle);
    end

    // Cycles spent in the current state; restarts on every state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_cnt_q <= '0;
        end else if (state_d != state_q) begin
            phase_cnt_q <= '0;
        end else if (state_q inside {StArm, StWaitGo, StScan}) begin
            phase_cnt_q <= phase_cnt_q + PH_W'(1);
        end
    end

    // Buffer swap and game handshake. A swap only happens with back_ready set,
    // which implies upd_req is low, so an ack can never collide with a swap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_sel_q    <= 1'b0;
            upd_req_q    <= 1'b1;
            back_ready_q <= 1'b0;
        end else if (swap_evt && back_ready_q) begin
            buf_sel_q    <= ~buf_sel_q;
            back_ready_q <= 1'b0;
            upd_req_q    <= 1'b1;
        end else if (upd_req_q && upd_ack_i) begin
            upd_req_q    <= 1'b0;
            back_ready_q <= 1'b1;
        end
    end

    // Completed-scan counter, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if (done_evt) begin
            frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
        end
    end

    // Sticky error flags; a new event beats a clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (overrun_evt) begin
                overrun_q <= 1'b1;
            end else if (clr_i) begin
                overrun_q <= 1'b0;
            end
            if (timeout_evt) begin
                timeout_q <= 1'b1;
            end else if (clr_i) begin
                timeout_q <= 1'b0;
            end
        end
    end

`ifdef FRAME_SCHED_STATS_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q;
    logic                  drop_evt;

    assign drop_evt = swap_evt && !back_ready_q;

    // Repeated-frame counter; an increment beats a clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else if (clr_i) begin
            drop_cnt_q <= drop_evt ? DROP_CNT_W'(1) : '0;
        end else if (drop_evt && (drop_cnt_q != {DROP_CNT_W{1'b1}})) begin
            drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`else
    assign drop_cnt_o = '0;
`endif

    assign buf_sel_o   = buf_sel_q;
    assign upd_req_o   = upd_req_q;
    assign frame_cnt_o = frame_cnt_q;
    assign overrun_o   = overrun_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Scoreboard bench for frame_scheduler. A frame-level reference model pushes
// expected start pulses and completed frames; a monitor pops and compares
// them as the DUT produces them. A second instance with a long driver scan
// exercises the overrun path.
`timescale 1ns/1ps
module tb_frame_scheduler;

    localparam int PERIOD    = 200;
    localparam int PULSE     = 4;
    localparam int TMO       = 64;
    localparam int SCAN_LEN  = 40;
    localparam int LONG_SCAN = 250;
`ifdef FRAME_SCHED_STATS_EN
    localparam int EXP3 = 3;
`else
    localparam int EXP3 = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst2;
    logic        enable, clr, upd_ack;
    logic [2:0]  drv_state;
    logic        drv_start, buf_sel, upd_req, busy, overrun, timeout;
    logic [15:0] frame_cnt;
    logic [7:0]  drop_cnt;

    logic        enable2, clr2, ack2;
    logic [2:0]  drv_state2;
    logic        drv_start2, buf_sel2, upd_req2, busy2, overrun2, timeout2;
    logic [15:0] frame_cnt2;
    logic [7:0]  drop_cnt2;

    frame_scheduler #(
        .FRAME_PERIOD    (PERIOD),
        .START_PULSE_LEN (PULSE),
        .DRV_TIMEOUT     (TMO),
        .DRV_HALT        (3'd7)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .enable_i    (enable),
        .clr_i       (clr),
        .drv_state_i (drv_state),
        .drv_start_o (drv_start),
        .buf_sel_o   (buf_sel),
        .upd_req_o   (upd_req),
        .upd_ack_i   (upd_ack),
        .busy_o      (busy),
        .frame_cnt_o (frame_cnt),
        .overrun_o   (overrun),
        .timeout_o   (timeout),
        .drop_cnt_o  (drop_cnt)
    );

    frame_scheduler #(
        .FRAME_PERIOD    (PERIOD),
        .START_PULSE_LEN (PULSE),
        .DRV_TIMEOUT     (1000),
        .DRV_HALT        (3'd7)
    ) u_dut_long (
        .clk         (clk),
        .rst         (rst2),
        .enable_i    (enable2),
        .clr_i       (clr2),
        .drv_state_i (drv_state2),
        .drv_start_o (drv_start2),
        .buf_sel_o   (buf_sel2),
        .upd_req_o   (upd_req2),
        .upd_ack_i   (ack2),
        .busy_o      (busy2),
        .frame_cnt_o (frame_cnt2),
        .overrun_o   (overrun2),
        .timeout_o   (timeout2),
        .drop_cnt_o  (drop_cnt2)
    );

    // Behavioural driver: scans for a fixed time after the start falling edge.
    bit   stuck = 1'b0;
    int   scan_left = 0;
    logic start_prev = 1'b0;
    always @(posedge clk) begin
        start_prev <= drv_start;
        if (scan_left > 0) scan_left <= scan_left - 1;
        else if (start_prev && !drv_start && !stuck) scan_left <= SCAN_LEN;
    end
    assign drv_state = (scan_left > 0) ? 3'd1 : 3'd7;

    int   scan2_left = 0;
    logic start2_prev = 1'b0;
    int   start2_cnt = 0;
    always @(posedge clk) begin
        start2_prev <= drv_start2;
        if (scan2_left > 0) scan2_left <= scan2_left - 1;
        else if (start2_prev && !drv_start2) scan2_left <= LONG_SCAN;
        if (rst2) start2_cnt <= 0;
        else if (drv_start2 && !start2_prev) start2_cnt <= start2_cnt + 1;
    end
    assign drv_state2 = (scan2_left > 0) ? 3'd2 : 3'd7;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cur_cyc);
        end
    endtask

    // Reference model at frame level.
    typedef struct { int cyc; bit bsel; } start_rec_t;
    typedef struct { int cnt; bit bsel; int drops; } done_rec_t;
    start_rec_t start_q[$];
    done_rec_t  done_q[$];

    bit m_buf, m_rend, m_req;
    int m_cnt, m_drops, swap_at;
    int cur_cyc = 0;
    bit mon_en = 1'b0;

    task automatic model_reset();
        m_buf = 1'b0; m_rend = 1'b0; m_req = 1'b1;
        m_cnt = 0; m_drops = 0; swap_at = -1;
    endtask

    function automatic int exp_drops();
`ifdef FRAME_SCHED_STATS_EN
        return m_drops;
`else
        return 0;
`endif
    endfunction

    // Effect of one cycle of inputs: swap uses the buffer state from before
    // any ack in the same cycle; an ack counts only while a request is open.
    task automatic model_cycle(input int c, input bit ack, input bit en, input bit clr_now);
        bit req_now;
        req_now = m_req;
        if (clr_now) m_drops = 0;
        if (c == swap_at) begin
            if (m_rend) begin
                m_buf = !m_buf; m_rend = 1'b0; m_req = 1'b1;
            end else if (m_drops < 255) begin
                m_drops++;
            end
            start_q.push_back('{c + 1, m_buf});
            if (!stuck) begin
                m_cnt = (m_cnt + 1) % 65536;
                done_q.push_back('{m_cnt, m_buf, exp_drops()});
            end
            swap_at = -1;
        end
        if (ack && req_now) begin
            m_req = 1'b0; m_rend = 1'b1;
        end
        if ((c % PERIOD) == PERIOD - 1 && en) swap_at = c + 1;
    endtask

    task automatic step(input bit ack, input bit en, input bit clr_now);
        upd_ack = ack; enable = en; clr = clr_now;
        model_cycle(cur_cyc, ack, en, clr_now);
        @(posedge clk);
        cur_cyc++;
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_upd_req"},   upd_req,   1);
        chk({tag, "_buf_sel"},   buf_sel,   0);
        chk({tag, "_busy"},      busy,      0);
        chk({tag, "_drv_start"}, drv_start, 0);
        chk({tag, "_frame_cnt"}, frame_cnt, 0);
        chk({tag, "_overrun"},   overrun,   0);
        chk({tag, "_timeout"},   timeout,   0);
        chk({tag, "_drop_cnt"},  drop_cnt,  0);
    endtask

    // Monitor: compares DUT events against the scoreboard queues.
    initial begin
        logic        p_start;
        logic [15:0] p_cnt;
        int          hi_len;
        start_rec_t  sr;
        done_rec_t   dr;
        p_start = 1'b0; p_cnt = '0; hi_len = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (drv_start && !p_start) begin
                    if (start_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL start_unexpected: got pulse at cycle %0d, expected none",
                                 cur_cyc);
                    end else begin
                        sr = start_q.pop_front();
                        chk("start_cycle", cur_cyc, sr.cyc);
                        chk("start_buf_sel", buf_sel, sr.bsel);
                    end
                end
                if (drv_start) begin
                    hi_len++;
                end else if (p_start) begin
                    chk("pulse_len", hi_len, PULSE);
                    hi_len = 0;
                end
                if (frame_cnt != p_cnt) begin
                    if (done_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL done_unexpected: got frame_cnt %0d, expected no change",
                                 frame_cnt);
                    end else begin
                        dr = done_q.pop_front();
                        chk("done_frame_cnt", frame_cnt, dr.cnt);
                        chk("done_buf_sel", buf_sel, dr.bsel);
                        chk("done_drop_cnt", drop_cnt, dr.drops);
                    end
                end
            end else begin
                hi_len = 0;
            end
            p_start = drv_start;
            p_cnt   = frame_cnt;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit a, e, cl;
        bit c_buf, d_buf;
        rst = 1'b1; rst2 = 1'b1;
        enable = 1'b0; clr = 1'b0; upd_ack = 1'b0;
        enable2 = 1'b0; clr2 = 1'b0; ack2 = 1'b0;
        c_buf = 1'b0; d_buf = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        rst = 1'b0; cur_cyc = 0; mon_en = 1'b1;

        while (cur_cyc < 3430) begin
            a = 1'b0; e = 1'b1; cl = 1'b0;
            if (cur_cyc == 20 || cur_cyc == 2800) a = 1'b1;
            if (cur_cyc >= 400 && cur_cyc < 1600) begin
                a = ($urandom_range(0, 59) == 0);
                e = ($urandom_range(0, 3) != 0);
            end
            if (cur_cyc == 1900 || cur_cyc == 3300) cl = 1'b1;
            if (cur_cyc == 1900) c_buf = m_buf;
            if (cur_cyc == 2600) d_buf = m_buf;
            if (cur_cyc == 3200) stuck = 1'b1;
            if (cur_cyc == 3350) stuck = 1'b0;

            if (cur_cyc == 199) chk("req_low_after_ack", upd_req, 0);
            if (cur_cyc == 200) chk("start_low_in_swap", drv_start, 0);
            if (cur_cyc == 200) chk("buf_before_swap", buf_sel, 0);
            if (cur_cyc == 201) chk("req_reassert", upd_req, 1);
            if (cur_cyc == 201) chk("buf_after_swap", buf_sel, 1);
            if (cur_cyc == 204) chk("start_last_cycle", drv_start, 1);
            if (cur_cyc == 205) chk("start_dropped", drv_start, 0);
            if (cur_cyc == 248) chk("first_frame_cnt", frame_cnt, 1);
            if (cur_cyc == 2450) chk("drop_after_3", drop_cnt, EXP3);
            if (cur_cyc == 2450) chk("buf_held_no_ack", buf_sel, c_buf);
            if (cur_cyc == 2801) chk("same_cycle_ack_no_swap", buf_sel, d_buf);
            if (cur_cyc == 2801) chk("same_cycle_ack_taken", upd_req, 0);
            if (cur_cyc == 3001) chk("swap_next_frame", buf_sel, !d_buf);
            if (cur_cyc == 3001) chk("req_after_late_swap", upd_req, 1);
            if (cur_cyc == 3268) chk("timeout_not_yet", timeout, 0);
            if (cur_cyc == 3268) chk("busy_in_waitgo", busy, 1);
            if (cur_cyc == 3269) chk("timeout_set", timeout, 1);
            if (cur_cyc == 3269) chk("idle_after_timeout", busy, 0);
            if (cur_cyc == 3269) chk("cnt_after_timeout", frame_cnt, m_cnt);
            if (cur_cyc == 3301) chk("timeout_cleared", timeout, 0);
            step(a, e, cl);
        end

        // Reset mid-scan, checked before any clock edge.
        chk("busy_before_reset", busy, 1);
        mon_en = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset_vals("async");
        @(negedge clk);
        start_q.delete();
        done_q.delete();
        model_reset();
        rst = 1'b0; rst2 = 1'b0; enable2 = 1'b1;
        cur_cyc = 0; mon_en = 1'b1;

        while (cur_cyc < 600) begin
            if (cur_cyc == 203) chk("long_start_high", drv_start2, 1);
            if (cur_cyc == 398) chk("long_overrun_not_yet", overrun2, 0);
            if (cur_cyc == 398) chk("long_busy_scan", busy2, 1);
            if (cur_cyc == 400) chk("long_overrun_set", overrun2, 1);
            if (cur_cyc == 400) chk("long_still_busy", busy2, 1);
            if (cur_cyc == 460) chk("long_frame_cnt", frame_cnt2, 1);
            if (cur_cyc == 460) chk("long_idle", busy2, 0);
            if (cur_cyc == 460) chk("long_one_start", start2_cnt, 1);
            step($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, 1'b0);
        end

        chk("start_q_drained", start_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);
        chk("no_overrun_short", overrun, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
